// File: rtl/rv_ma_lsu.sv
// rv_ma_lsu: memory-access stage (Q103H -> Q104H) with a valid/ready
// request channel and a variable-latency response channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   valid/ld_en/st_en_Q103H  instruction present, load, store
//   funct3_Q103H             [1:0] size (B/H/W/D), [2] unsigned load
//   sel_wb_Q103H             write-back select: PC+4 / ALU / DMEM / zero
//   alu_out_Q103H            effective address or ALU result
//   pc_plus4_Q103H           PC+4 for link write-back
//   st_data_Q103H            store data, value in the low bytes
//   dmem_req_*               request channel (aligned addr, byte enables,
//                            lane-shifted write data)
//   dmem_rsp_*               response channel (full aligned word)
//   stall_Q103H              holds Q103H and earlier until the access is done
//   misalign_Q103H           misaligned/illegal access flag (combinational)
//   timeout_err              one-cycle pulse after a hung load is aborted
//   wb_valid/wb_data_Q104H   write-back stage outputs
module rv_ma_lsu #(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255,
  parameter int TW          = $clog2(RSP_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_Q103H,
  input  logic            ld_en_Q103H,
  input  logic            st_en_Q103H,
  input  logic [2:0]      funct3_Q103H,
  input  logic [1:0]      sel_wb_Q103H,
  input  logic [XLEN-1:0] alu_out_Q103H,
  input  logic [XLEN-1:0] pc_plus4_Q103H,
  input  logic [XLEN-1:0] st_data_Q103H,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wr_en,
  output logic [XLEN/8-1:0] dmem_req_byte_en,
  output logic [XLEN-1:0] dmem_req_wr_data,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_data,
  output logic            stall_Q103H,
  output logic            misalign_Q103H,
  output logic            timeout_err,
  output logic            wb_valid_Q104H,
  output logic [XLEN-1:0] wb_data_Q104H
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic {S_IDLE, S_WAIT_RSP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            timeout_err_q, timeout_err_d;

  logic            mem_op, misaligned, req_valid;
  logic            st_hs, ld_hs, ld_rsp, abort, done, completed;
  logic [OW-1:0]   off;
  logic [XLEN-1:0] ld_data, wb_mux;

  // Select the addressed lane of the response word and extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                   input logic [OW-1:0]   lane_off,
                                                   input logic [2:0]      f3);
    logic [XLEN-1:0] lane;
    lane = data >> {lane_off, 3'b000};
    case (f3[1:0])
      2'd0:    return f3[2] ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'd1:    return f3[2] ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'd2:    return f3[2] ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: return data;
    endcase
  endfunction

  // Q103H decode: alignment check and request payload
  always_comb begin
    mem_op = valid_Q103H & (ld_en_Q103H | st_en_Q103H);
    off    = alu_out_Q103H[OW-1:0];
    case (funct3_Q103H[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = (XLEN == 32) ? 1'b1 : |off;  // D is illegal on RV32
    endcase
    dmem_req_addr    = alu_out_Q103H & ~XLEN'(NB - 1);
    dmem_req_wr_data = st_data_Q103H << {off, 3'b000};
    dmem_req_wr_en   = st_en_Q103H;
    dmem_req_byte_en = '0;
    for (int i = 0; i < NB; i++)
      dmem_req_byte_en[i] = (i >= int'(off)) && (i < int'(off) + (1 << int'(funct3_Q103H[1:0])));
  end

  // FSM outputs and completion
  always_comb begin
    req_valid = 1'b0;
    st_hs     = 1'b0;
    ld_hs     = 1'b0;
    ld_rsp    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_valid = mem_op & ~misaligned;
        st_hs     = req_valid & dmem_req_ready & st_en_Q103H;
        ld_hs     = req_valid & dmem_req_ready & ld_en_Q103H;
      end
      default: begin
        // A response in the final counted cycle still wins over the abort.
        ld_rsp = dmem_rsp_valid;
        abort  = ~dmem_rsp_valid & (cnt_q == TW'(RSP_TIMEOUT - 1));
      end
    endcase
    done           = st_hs | ld_rsp | abort;
    stall_Q103H    = mem_op & ~misaligned & ~done;
    misalign_Q103H = mem_op & misaligned;
    dmem_req_valid = req_valid;
  end

  // FSM next state and Q104H next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      S_IDLE: begin
        if (ld_hs) begin
          state_d = S_WAIT_RSP;
          cnt_d   = '0;
          off_d   = off;
          f3_d    = funct3_Q103H;
        end
      end
      default: begin
        cnt_d = cnt_q + TW'(1);
        if (ld_rsp | abort) state_d = S_IDLE;
      end
    endcase

    ld_data = load_extract(dmem_rsp_data, off_q, f3_q);
    case (sel_wb_Q103H)
      2'd0:    wb_mux = pc_plus4_Q103H;
      2'd1:    wb_mux = alu_out_Q103H;
      2'd2:    wb_mux = ld_data;
      default: wb_mux = '0;
    endcase

    // Faulted and aborted accesses never produce a write-back.
    completed     = valid_Q103H & (~(ld_en_Q103H | st_en_Q103H) | st_hs | ld_rsp);
    wb_valid_d    = completed;
    wb_data_d     = completed ? wb_mux : wb_data_q;
    timeout_err_d = abort;
  end

  // Q103H -> Q104H boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      timeout_err_q <= timeout_err_d;
    end
    off_q <= off_d;
    f3_q  <= f3_d;
  end

  assign wb_valid_Q104H = wb_valid_q;
  assign wb_data_Q104H  = wb_data_q;
  assign timeout_err    = timeout_err_q;

endmodule
